hall_sequence_gen: RTL

Generates a 3-bit Hall-sensor code stream that mimics a rotating BLDC motor. Steps are produced either at a programmable rate or one at a time on request. Used as the stimulus/emulation source on the FPGA, so the hall decoding path and commutation logic can be exercised without a spinning motor. Also tracks the emulated position with the same up/down sign convention the hall decoding path uses.

---
 rtl/hall_pkg.sv | 47 ++++
 rtl/hall_step_timer.sv | 44 ++++
 rtl/hall_sequence_gen.sv | 75 +++++++
 3 files changed

// File: rtl/hall_pkg.sv
// rtl/hall_pkg.sv - hall code table, invalid codes and index stepping helpers
package hall_pkg;

    localparam logic [2:0] STEP_1 = 3'b101;
    localparam logic [2:0] STEP_2 = 3'b100;
    localparam logic [2:0] STEP_3 = 3'b110;
    localparam logic [2:0] STEP_4 = 3'b010;
    localparam logic [2:0] STEP_5 = 3'b011;
    localparam logic [2:0] STEP_6 = 3'b001;

    localparam logic [2:0] HALL_INVALID_LO = 3'b000;
    localparam logic [2:0] HALL_INVALID_HI = 3'b111;

    localparam logic [2:0] IDX_FIRST = 3'd0;
    localparam logic [2:0] IDX_LAST  = 3'd5;

    typedef enum logic {
        DIR_REV = 1'b0,
        DIR_FWD = 1'b1
    } hall_dir_e;

    // Indices 6 and 7 never occur in normal operation; they map to an invalid code.
    function automatic logic [2:0] hall_code(input logic [2:0] index);
        logic [2:0] code;
        case (index)
            3'd0:    code = STEP_1;
            3'd1:    code = STEP_2;
            3'd2:    code = STEP_3;
            3'd3:    code = STEP_4;
            3'd4:    code = STEP_5;
            3'd5:    code = STEP_6;
            default: code = HALL_INVALID_LO;
        endcase
        return code;
    endfunction

    function automatic logic [2:0] next_index(input logic [2:0] index, input hall_dir_e dir);
        logic [2:0] nxt;
        if (dir == DIR_FWD) begin
            nxt = (index >= IDX_LAST) ? IDX_FIRST : index + 3'd1;
        end else begin
            nxt = (index == IDX_FIRST || index > IDX_LAST) ? IDX_LAST : index - 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hall_step_timer.sv
// rtl/hall_step_timer.sv - step rate timer and manual step muxing, one step_fire pulse per step
module hall_step_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                step_req,
    output logic                step_fire
);

    localparam logic [PERIOD_W-1:0] ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] ZERO = '0;

    logic [PERIOD_W-1:0] timer_q;
    logic [PERIOD_W-1:0] timer_d;
    logic                running;
    logic                rate_fire;
    logic                manual_fire;

    // Compare against the live period so a shortened period can fire immediately.
    always_comb begin
        running     = enable && (period != ZERO);
        rate_fire   = running && (timer_q >= (period - ONE));
        manual_fire = !enable && step_req;
        step_fire   = rate_fire || manual_fire;
        timer_d     = timer_q;
        if (!running || rate_fire) begin
            timer_d = ZERO;
        end else begin
            timer_d = timer_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= ZERO;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/hall_sequence_gen.sv
// rtl/hall_sequence_gen.sv - emulated BLDC hall code stream with position tracking
module hall_sequence_gen
    import hall_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int POS_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                dir,
    input  logic [PERIOD_W-1:0] period,
    input  logic                step_req,
    input  logic                fault_inject,
    output logic [2:0]          hall,
    output logic                step_strobe,
    output logic [POS_W-1:0]    position
);

    localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

    logic             step_fire;
    logic [2:0]       index_q,    index_d;
    logic [2:0]       hall_q,     hall_d;
    logic             strobe_q,   strobe_d;
    logic [POS_W-1:0] position_q, position_d;
    hall_dir_e        dir_e;

    hall_step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_step_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .period    (period),
        .step_req  (step_req),
        .step_fire (step_fire)
    );

    // dir only matters on a step, so a toggle between steps cannot skip a code.
    always_comb begin
        dir_e      = hall_dir_e'(dir);
        index_d    = index_q;
        position_d = position_q;
        strobe_d   = step_fire;
        if (step_fire) begin
            index_d = next_index(index_q, dir_e);
            if (dir_e == DIR_FWD) begin
                position_d = position_q + POS_ONE;
            end else begin
                position_d = position_q - POS_ONE;
            end
        end
        hall_d = fault_inject ? HALL_INVALID_LO : hall_code(index_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q    <= IDX_FIRST;
            hall_q     <= STEP_1;
            strobe_q   <= 1'b0;
            position_q <= '0;
        end else begin
            index_q    <= index_d;
            hall_q     <= hall_d;
            strobe_q   <= strobe_d;
            position_q <= position_d;
        end
    end

    assign hall        = hall_q;
    assign step_strobe = strobe_q;
    assign position    = position_q;

endmodule
